// File: rtl/mixer_pkg.sv
// ---------------------------------------------------------------------------
// mixer_pkg
// Shared definitions for the multi-channel encoder-to-PWM mixer.
//   DEF_WIDTH, DEF_DEBOUNCE_LOG2 : default level width and debounce strobe exponent
//   step_t                       : decoded encoder step for one channel
//   next_level()                 : applies one step to a level with saturate/wrap rules.
//                                  Arguments are carried at 16 bits, the widest
//                                  supported level, and callers narrow the result.
// ---------------------------------------------------------------------------
package mixer_pkg;

    localparam int DEF_WIDTH         = 8;
    localparam int DEF_DEBOUNCE_LOG2 = 8;

    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_UP   = 2'd1,
        STEP_DOWN = 2'd2
    } step_t;

    function automatic logic [15:0] next_level(
        input logic [15:0] level,
        input step_t       step,
        input logic        wrap,
        input logic [15:0] max
    );
        logic [15:0] res;
        res = level;
        case (step)
            STEP_UP: begin
                if (level == max) res = wrap ? 16'd0 : max;
                else              res = level + 16'd1;
            end
            STEP_DOWN: begin
                if (level == 16'd0) res = wrap ? max : 16'd0;
                else                res = level - 16'd1;
            end
            default: res = level;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mixer_channel.sv
// ---------------------------------------------------------------------------
// mixer_channel
// One encoder/PWM channel: 2-flop synchronisers on A and B, strobe-driven
// debounce, rising-A quadrature decode, level register, period-shadowed duty
// and registered PWM compare.
// Optional build macro: MIXER_LOAD_EN adds a direct level load port.
//
// Ports
//   clk, reset      : system clock, synchronous active-high reset
//   i_enc_a/i_enc_b : raw encoder phases (asynchronous)
//   i_mode_wrap     : 0 = saturate at bounds, 1 = wrap
//   i_strobe        : debounce sample strobe from the shared prescaler
//   i_period_cnt    : shared PWM period counter
//   i_period_last   : high on the last cycle of each PWM period
//   i_load_en       : (MIXER_LOAD_EN) load i_load_value into the level
//   i_load_value    : (MIXER_LOAD_EN) value to load
//   o_pwm           : registered PWM output
//   o_level         : current level register
// ---------------------------------------------------------------------------
module mixer_channel
    import mixer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_enc_a,
    input  logic             i_enc_b,
    input  logic             i_mode_wrap,
    input  logic             i_strobe,
    input  logic [WIDTH-1:0] i_period_cnt,
    input  logic             i_period_last,
`ifdef MIXER_LOAD_EN
    input  logic             i_load_en,
    input  logic [WIDTH-1:0] i_load_value,
`endif
    output logic             o_pwm,
    output logic [WIDTH-1:0] o_level
);

    localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};

    logic [1:0]       r_a_sync;
    logic [1:0]       r_b_sync;
    logic             r_a_samp;
    logic             r_b_samp;
    logic             r_a_deb;
    logic             r_b_deb;
    logic             r_a_prev;
    logic [WIDTH-1:0] r_level;
    logic [WIDTH-1:0] r_duty;
    logic             r_pwm;

    step_t            w_step;
    logic [WIDTH-1:0] w_level_next;

    // Stage: synchronise asynchronous encoder phases
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a_sync <= 2'b00;
            r_b_sync <= 2'b00;
        end else begin
            r_a_sync <= {r_a_sync[0], i_enc_a};
            r_b_sync <= {r_b_sync[0], i_enc_b};
        end
    end

    // Stage: debounce - accept a sample only when two consecutive strobes agree
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a_samp <= 1'b0;
            r_b_samp <= 1'b0;
            r_a_deb  <= 1'b0;
            r_b_deb  <= 1'b0;
            r_a_prev <= 1'b0;
        end else begin
            if (i_strobe) begin
                r_a_samp <= r_a_sync[1];
                r_b_samp <= r_b_sync[1];
                if (r_a_sync[1] == r_a_samp) r_a_deb <= r_a_sync[1];
                if (r_b_sync[1] == r_b_samp) r_b_deb <= r_b_sync[1];
            end
            r_a_prev <= r_a_deb;
        end
    end

    // Stage: decode - one step per debounced rising edge of A, direction from B
    always_comb begin
        w_step = STEP_NONE;
        if (r_a_deb && !r_a_prev) begin
            w_step = r_b_deb ? STEP_DOWN : STEP_UP;
        end
    end

    assign w_level_next = WIDTH'(next_level(16'(r_level), w_step, i_mode_wrap, 16'(MAX)));

    // Stage: level register (a load overrides a same-cycle step)
    always_ff @(posedge clk) begin
        if (reset) begin
            r_level <= '0;
`ifdef MIXER_LOAD_EN
        end else if (i_load_en) begin
            r_level <= i_load_value;
`endif
        end else begin
            r_level <= w_level_next;
        end
    end

    // Stage: duty shadow, refreshed only on the last cycle of a period
    always_ff @(posedge clk) begin
        if (reset) begin
            r_duty <= '0;
        end else if (i_period_last) begin
            r_duty <= r_level;
        end
    end

    // Stage: PWM compare; the counter never reaches MAX, so duty MAX stays high
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pwm <= 1'b0;
        end else begin
            r_pwm <= (i_period_cnt < r_duty);
        end
    end

    assign o_pwm   = r_pwm;
    assign o_level = r_level;

endmodule

// File: rtl/multi_channel_rgb_mixer.sv
// ---------------------------------------------------------------------------
// multi_channel_rgb_mixer
// NUM_CH quadrature encoders, each stepping one WIDTH-bit level that sets the
// duty of one PWM output. A shared prescaler produces the debounce strobe and
// a shared period counter (0 .. 2^WIDTH-2) drives every PWM compare.
// Optional build macro: MIXER_LOAD_EN adds load_valid/load_ch/load_value for
// writing a level directly.
//
// Ports
//   clk        : system clock
//   reset      : synchronous active-high reset
//   enc_a      : [NUM_CH] encoder A phases (asynchronous)
//   enc_b      : [NUM_CH] encoder B phases (asynchronous)
//   mode_wrap  : 0 = saturate at bounds, 1 = wrap at bounds
//   load_valid : (MIXER_LOAD_EN) load strobe
//   load_ch    : (MIXER_LOAD_EN) target channel; out-of-range values ignored
//   load_value : (MIXER_LOAD_EN) level to load
//   pwm_out    : [NUM_CH] PWM outputs
//   level_out  : [NUM_CH*WIDTH] levels, channel i at [i*WIDTH +: WIDTH]
// ---------------------------------------------------------------------------
module multi_channel_rgb_mixer
    import mixer_pkg::*;
#(
    parameter  int NUM_CH        = 3,
    parameter  int WIDTH         = DEF_WIDTH,
    parameter  int DEBOUNCE_LOG2 = DEF_DEBOUNCE_LOG2,
    localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
)
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       enc_a,
    input  logic [NUM_CH-1:0]       enc_b,
    input  logic                    mode_wrap,
`ifdef MIXER_LOAD_EN
    input  logic                    load_valid,
    input  logic [CH_W-1:0]         load_ch,
    input  logic [WIDTH-1:0]        load_value,
`endif
    output logic [NUM_CH-1:0]       pwm_out,
    output logic [NUM_CH*WIDTH-1:0] level_out
);

    localparam logic [WIDTH-1:0] CNT_LAST = {{(WIDTH-1){1'b1}}, 1'b0};

    logic [DEBOUNCE_LOG2-1:0] r_presc;
    logic [WIDTH-1:0]         r_period_cnt;
    logic                     w_strobe;
    logic                     w_period_last;

    // Stage: shared prescaler and PWM period counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc      <= '0;
            r_period_cnt <= '0;
        end else begin
            r_presc <= r_presc + DEBOUNCE_LOG2'(1);
            if (w_period_last) r_period_cnt <= '0;
            else               r_period_cnt <= r_period_cnt + WIDTH'(1);
        end
    end

    assign w_strobe      = &r_presc;
    assign w_period_last = (r_period_cnt == CNT_LAST);

    // Stage: per-channel datapath
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
`ifdef MIXER_LOAD_EN
        logic w_load_hit;
        // load_ch values at or above NUM_CH match no channel and are dropped
        assign w_load_hit = load_valid && (int'(load_ch) == gi);
`endif
        mixer_channel #(
            .WIDTH (WIDTH)
        ) u_ch (
            .clk           (clk),
            .reset         (reset),
            .i_enc_a       (enc_a[gi]),
            .i_enc_b       (enc_b[gi]),
            .i_mode_wrap   (mode_wrap),
            .i_strobe      (w_strobe),
            .i_period_cnt  (r_period_cnt),
            .i_period_last (w_period_last),
`ifdef MIXER_LOAD_EN
            .i_load_en     (w_load_hit),
            .i_load_value  (load_value),
`endif
            .o_pwm         (pwm_out[gi]),
            .o_level       (level_out[gi*WIDTH +: WIDTH])
        );
    end

endmodule
